// File: rtl/seg_pkg.sv
// Seven-segment constants: hex glyph table, blank code and segment bit positions.
// Definitions only; no timing or flow control.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Glyphs are logical (1 = lit), bit 0 = segment a
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex nibble to seven-segment glyph, purely combinational (0 cycles).
// No flow control; output follows input.
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_HEX_0;
        case (nibble)
            4'h0: segs = SEG_HEX_0;
            4'h1: segs = SEG_HEX_1;
            4'h2: segs = SEG_HEX_2;
            4'h3: segs = SEG_HEX_3;
            4'h4: segs = SEG_HEX_4;
            4'h5: segs = SEG_HEX_5;
            4'h6: segs = SEG_HEX_6;
            4'h7: segs = SEG_HEX_7;
            4'h8: segs = SEG_HEX_8;
            4'h9: segs = SEG_HEX_9;
            4'hA: segs = SEG_HEX_A;
            4'hB: segs = SEG_HEX_B;
            4'hC: segs = SEG_HEX_C;
            4'hD: segs = SEG_HEX_D;
            4'hE: segs = SEG_HEX_E;
            4'hF: segs = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed hex display scanner with shadowed data, leading-zero blanking and blink; seg/an registered, 1 cycle latency.
// No backpressure: free-running scan, load is accepted on any cycle.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int DIV_W = (CLK_DIV > 1)      ? $clog2(CLK_DIV)      : 1;
    localparam int DIG_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [7:0]        SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [DIV_W-1:0]    div_cnt;
    logic [DIG_W-1:0]    digit_idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blink_phase;
    logic [4*DIGITS-1:0] data_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   blink_sh;

    logic                div_tc;
    logic                dig_tc;
    logic                frm_tc;
    logic [3:0]          cur_nib;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   lead_zero;
    logic                blank;
    logic [7:0]          seg_log;
    logic [DIGITS-1:0]   an_log;

    assign div_tc = (div_cnt == DIV_LAST);
    assign dig_tc = (digit_idx == DIG_LAST);
    assign frm_tc = (frame_cnt == FRM_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                digit_idx <= dig_tc ? '0 : digit_idx + 1'b1;
                if (dig_tc) begin
                    frame_cnt <= frm_tc ? '0 : frame_cnt + 1'b1;
                    if (frm_tc) begin
                        blink_phase <= ~blink_phase;
                    end
                end
            end
        end
    end

    // Whole word captured in one edge so the display never shows a half-updated value
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sh  <= '0;
            dp_sh    <= '0;
            blink_sh <= '0;
        end else if (load) begin
            data_sh  <= data;
            dp_sh    <= dp;
            blink_sh <= blink_mask;
        end
    end

    assign cur_nib = data_sh[{digit_idx, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .nibble (cur_nib),
        .segs   (glyph)
    );

    // lead_zero[i] is set when nibble i and every nibble above it are zero
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lead_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero & (data_sh[4*i +: 4] == 4'h0);
            lead_zero[i] = upper_zero;
        end
    end

    always_comb begin
        blank = (lz_en && (digit_idx != '0) && lead_zero[digit_idx]) ||
                (blink_phase && blink_sh[digit_idx]);
        seg_log                = SEG_OFF;
        seg_log[SEG_G:SEG_A]   = glyph;
        seg_log[SEG_DP]        = dp_sh[digit_idx];
        if (blank) begin
            seg_log = SEG_OFF;
        end
        an_log            = '0;
        an_log[digit_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF ^ SEG_POL;
            an  <= AN_POL;
        end else begin
            seg <= seg_log ^ SEG_POL;
            an  <= an_log ^ AN_POL;
        end
    end

endmodule
